// File: rtl/bcd_binary_converter_seq_if.sv
// Handshake bundle for the sequential BCD-to-binary converter.
// master = producer/consumer side (testbench), slave = converter.
interface bcd_binary_converter_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] binary;
  logic       error;

  modport master (
    output in_valid, hundreds, tens, ones, out_ready,
    input  in_ready, out_valid, binary, error
  );

  modport slave (
    input  in_valid, hundreds, tens, ones, out_ready,
    output in_ready, out_valid, binary, error
  );
endinterface

// File: rtl/bcd_binary_converter_seq.sv
// Sequential 3-digit BCD to 8-bit binary converter (reverse double-dabble).
// Accepts one value in IDLE, runs 8 shift/correct steps, then holds the
// result in DONE until the consumer takes it.
module bcd_binary_converter_seq #(
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  bcd_binary_converter_seq_if.slave   bus
);

  // Output width; the algorithm only works for exactly 8 steps.
  localparam int         ITERATIONS = 8;
  localparam logic [2:0] LAST_CNT   = 3'(ITERATIONS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e      state_q,     state_d;
  logic [9:0]  scratch_q,   scratch_d;   // {hundreds[1:0], tens[3:0], ones[3:0]}
  logic [7:0]  acc_q,       acc_d;
  logic [2:0]  cnt_q,       cnt_d;
  logic [7:0]  binary_q,    binary_d;
  logic        error_q,     error_d;
  logic        out_valid_q, out_valid_d;

  logic [17:0] shifted;
  logic [9:0]  corrected;
  logic        illegal;
  logic        overflow;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.binary    = binary_q;
  assign bus.error     = error_q;

  // Next-state, datapath step and input screening.
  always_comb begin
    state_d     = state_q;
    scratch_d   = scratch_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    binary_d    = binary_q;
    error_d     = error_q;
    out_valid_d = out_valid_q;

    // One reverse double-dabble step: shift {scratch,acc} right, then pull
    // any digit that received a carried-in 8 back into BCD range.
    shifted   = {scratch_q, acc_q} >> 1;
    corrected = shifted[17:8];
    if (corrected[7:4] >= 4'd8) corrected[7:4] = corrected[7:4] - 4'd3;
    if (corrected[3:0] >= 4'd8) corrected[3:0] = corrected[3:0] - 4'd3;

    illegal  = (bus.tens > 4'd9) || (bus.ones > 4'd9);
    // BCD digit pairs order the same as their decimal values, so 8'h55 is 55.
    overflow = CHECK_RANGE &&
               ((bus.hundreds == 2'd3) ||
                ((bus.hundreds == 2'd2) && ({bus.tens, bus.ones} > 8'h55)));

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (illegal || overflow) begin
            binary_d    = 8'h00;
            error_d     = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            scratch_d = {bus.hundreds, bus.tens, bus.ones};
            acc_d     = 8'h00;
            cnt_d     = 3'd0;
            error_d   = 1'b0;
            state_d   = SHIFT;
          end
        end
      end
      SHIFT: begin
        scratch_d = corrected;
        acc_d     = shifted[7:0];
        cnt_d     = cnt_q + 3'd1;
        if (cnt_q == LAST_CNT) begin
          binary_d    = shifted[7:0];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      scratch_q   <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      binary_q    <= '0;
      error_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      scratch_q   <= scratch_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      binary_q    <= binary_d;
      error_q     <= error_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_bcd_binary_converter_seq.sv
// Bench for bcd_binary_converter_seq: range-checked and unchecked builds.
module tb_bcd_binary_converter_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] iv;            // per-DUT in_valid; [1]=range-checked, [0]=unchecked
  logic [1:0] h_r;
  logic [3:0] t_r, o_r;
  logic       out_ready_r;
  logic       sel;           // which DUT the helper tasks observe

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_binary_converter_seq_if bus1();
  bcd_binary_converter_seq_if bus0();

  assign bus1.in_valid  = iv[1];
  assign bus1.hundreds  = h_r;
  assign bus1.tens      = t_r;
  assign bus1.ones      = o_r;
  assign bus1.out_ready = out_ready_r;
  assign bus0.in_valid  = iv[0];
  assign bus0.hundreds  = h_r;
  assign bus0.tens      = t_r;
  assign bus0.ones      = o_r;
  assign bus0.out_ready = out_ready_r;

  bcd_binary_converter_seq #(.CHECK_RANGE(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  bcd_binary_converter_seq #(.CHECK_RANGE(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  logic       m_in_ready, m_out_valid, m_error;
  logic [7:0] m_binary;
  assign m_in_ready  = sel ? bus1.in_ready  : bus0.in_ready;
  assign m_out_valid = sel ? bus1.out_valid : bus0.out_valid;
  assign m_binary    = sel ? bus1.binary    : bus0.binary;
  assign m_error     = sel ? bus1.error     : bus0.error;

  typedef struct {
    logic [1:0] h;
    logic [3:0] t;
    logic [3:0] o;
    logic [7:0] bin;
    logic       err;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: decimal value from the digits, with screening rules.
  task automatic model(input bit cr, input logic [1:0] h, input logic [3:0] t, input logic [3:0] o,
                       output logic [7:0] b, output logic e, output int lat);
    int  v;
    bit  bad;
    v   = int'(h) * 100 + int'(t) * 10 + int'(o);
    bad = (t > 9) || (o > 9) || (cr && v > 255);
    b   = bad ? 8'h00 : 8'(v % 256);
    e   = bad;
    lat = bad ? 1 : 9;
  endtask

  // One full transaction. lat counts edges with the accept edge as 1.
  task automatic run_one(input bit s, input logic [1:0] h, input logic [3:0] t, input logic [3:0] o,
                         input int hold, output logic [7:0] b, output logic e, output int lat);
    int   guard;
    logic busy_bad, unstable;
    sel = s;
    @(negedge clk);
    guard = 0;
    while (!m_in_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("idle_before_accept", 32'(m_in_ready), 32'd1);
    h_r = h; t_r = t; o_r = o; iv[s] = 1'b1; out_ready_r = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    iv[s] = 1'b0;
    busy_bad = 1'b0;
    while (!m_out_valid && lat < 40) begin
      if (m_in_ready) busy_bad = 1'b1;
      @(posedge clk); lat++; @(negedge clk);
    end
    if (m_in_ready) busy_bad = 1'b1;
    chk("in_ready_low_while_busy", 32'(busy_bad), 32'd0);
    b = m_binary; e = m_error;
    unstable = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      if (m_binary !== b || m_error !== e || m_out_valid !== 1'b1) unstable = 1'b1;
    end
    chk("result_held_under_backpressure", 32'(unstable), 32'd0);
    out_ready_r = 1'b1;
    @(negedge clk);
    out_ready_r = 1'b0;
    chk("idle_after_handshake", 32'({m_out_valid, m_in_ready}), 32'b01);
  endtask

  task automatic run_and_check(input bit s, input bit cr, input logic [1:0] h, input logic [3:0] t,
                               input logic [3:0] o, input int hold);
    logic [7:0] b, eb;
    logic       e, ee;
    int         lat, el;
    model(cr, h, t, o, eb, ee, el);
    run_one(s, h, t, o, hold, b, e, lat);
    chk($sformatf("binary %0d.%0h.%0h", h, t, o), 32'(b), 32'(eb));
    chk($sformatf("error %0d.%0h.%0h", h, t, o), 32'(e), 32'(ee));
    chk($sformatf("latency %0d.%0h.%0h", h, t, o), 32'(lat), 32'(el));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vt[9];
    logic [7:0] b;
    logic       e;
    int         lat;

    vt[0] = '{2'd2, 4'd5, 4'd5, 8'hFF, 1'b0, 9};
    vt[1] = '{2'd0, 4'd0, 4'd0, 8'h00, 1'b0, 9};
    vt[2] = '{2'd2, 4'd5, 4'd6, 8'h00, 1'b1, 1};
    vt[3] = '{2'd0, 4'hA, 4'd0, 8'h00, 1'b1, 1};
    vt[4] = '{2'd0, 4'd3, 4'hF, 8'h00, 1'b1, 1};
    vt[5] = '{2'd3, 4'd0, 4'd0, 8'h00, 1'b1, 1};
    vt[6] = '{2'd1, 4'd2, 4'd8, 8'h80, 1'b0, 9};
    vt[7] = '{2'd0, 4'd9, 4'd9, 8'h63, 1'b0, 9};
    vt[8] = '{2'd2, 4'd0, 4'd0, 8'hC8, 1'b0, 9};

    rst_n = 1'b0; iv = 2'b00; h_r = '0; t_r = '0; o_r = '0; out_ready_r = 1'b0; sel = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset in_ready",  32'(bus1.in_ready),  32'd1);
    chk("reset out_valid", 32'(bus1.out_valid), 32'd0);
    chk("reset binary",    32'(bus1.binary),    32'd0);
    chk("reset error",     32'(bus1.error),     32'd0);
    rst_n = 1'b1;
    // out_ready with nothing pending must not disturb the idle block
    out_ready_r = 1'b1;
    repeat (3) @(negedge clk);
    out_ready_r = 1'b0;
    chk("idle out_ready no effect", 32'({bus1.out_valid, bus1.in_ready}), 32'b01);

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      run_one(1'b1, vt[i].h, vt[i].t, vt[i].o, i % 3, b, e, lat);
      chk($sformatf("table[%0d] binary", i),  32'(b),   32'(vt[i].bin));
      chk($sformatf("table[%0d] error", i),   32'(e),   32'(vt[i].err));
      chk($sformatf("table[%0d] latency", i), 32'(lat), 32'(vt[i].lat));
    end

    // Every legal value with random back-pressure
    for (int v = 0; v < 256; v++)
      run_and_check(1'b1, 1'b1, 2'(v / 100), 4'((v / 10) % 10), 4'(v % 10), int'($urandom_range(0, 3)));

    // Random digits including illegal and out-of-range ones
    for (int k = 0; k < 60; k++) begin
      logic [1:0] rh;
      logic [3:0] rt, ro;
      rh = 2'($urandom_range(0, 3));
      rt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      ro = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      run_and_check(1'b1, 1'b1, rh, rt, ro, int'($urandom_range(0, 2)));
    end

    // in_valid held high with changing data: only the accept-edge value counts,
    // and the next accept lands on the edge after the output handshake.
    sel = 1'b1;
    @(negedge clk);
    h_r = 2'd1; t_r = 4'd2; o_r = 4'd3; iv[1] = 1'b1; out_ready_r = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    while (!m_out_valid && lat < 40) begin
      h_r = 2'($urandom_range(0, 2)); t_r = 4'($urandom_range(0, 9)); o_r = 4'($urandom_range(0, 9));
      @(posedge clk); lat++; @(negedge clk);
    end
    chk("stream latency", 32'(lat), 32'd9);
    chk("stream binary",  32'(m_binary), 32'h7B);
    h_r = 2'd2; t_r = 4'd0; o_r = 4'd0;
    repeat (2) @(negedge clk);
    chk("stream held in DONE", 32'({m_out_valid, m_in_ready, m_binary}), 32'({2'b10, 8'h7B}));
    out_ready_r = 1'b1;
    @(negedge clk);
    chk("stream idle after handshake", 32'({m_out_valid, m_in_ready}), 32'b01);
    out_ready_r = 1'b0;
    @(negedge clk);
    chk("stream accepted next edge", 32'(m_in_ready), 32'd0);
    iv[1] = 1'b0;
    lat = 1;
    while (!m_out_valid && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
    chk("stream second latency", 32'(lat), 32'd9);
    chk("stream second binary",  32'(m_binary), 32'hC8);
    out_ready_r = 1'b1;
    @(negedge clk);
    out_ready_r = 1'b0;

    // Reset during the 4th shift cycle
    @(negedge clk);
    h_r = 2'd0; t_r = 4'd9; o_r = 4'd9; iv[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[1] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset in_ready",  32'(bus1.in_ready),  32'd1);
    chk("midreset out_valid", 32'(bus1.out_valid), 32'd0);
    chk("midreset binary",    32'(bus1.binary),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_one(1'b1, 2'd1, 4'd2, 4'd8, 1, b, e, lat);
    chk("after reset binary",  32'(b),   32'h80);
    chk("after reset error",   32'(e),   32'd0);
    chk("after reset latency", 32'(lat), 32'd9);

    // Unchecked build: values wrap modulo 256, digit checks remain
    run_one(1'b0, 2'd2, 4'd9, 4'd9, 1, b, e, lat);
    chk("nocheck 299 binary", 32'(b), 32'h2B);
    chk("nocheck 299 error",  32'(e), 32'd0);
    chk("nocheck 299 latency", 32'(lat), 32'd9);
    run_one(1'b0, 2'd3, 4'd0, 4'd0, 0, b, e, lat);
    chk("nocheck 300 binary", 32'(b), 32'h2C);
    run_one(1'b0, 2'd0, 4'hA, 4'd0, 0, b, e, lat);
    chk("nocheck illegal error",   32'(e),   32'd1);
    chk("nocheck illegal latency", 32'(lat), 32'd1);
    for (int k = 0; k < 20; k++)
      run_and_check(1'b0, 1'b0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 10)),
                    4'($urandom_range(0, 10)), int'($urandom_range(0, 2)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
